regfile_scoreboard: RTL and testbench

- General-purpose register file for the 16-bit pipelined core. It is the consumer end of the writeback interface: it accepts the writeback stage's result and destination, and provides two read ports to the decode stage.
- Combinational reads with same-cycle write-through bypass.
- Per-register pending-write counters (scoreboard). Decode uses these to detect RAW hazards on in-flight producers.

---
 rtl/regfile_scoreboard.sv | 124 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// General-purpose register file for the 16-bit pipelined core with
// write-through bypass and per-register pending-write counters that
// let decode detect RAW hazards on in-flight producers.
`timescale 1ns/1ps

module regfile_scoreboard #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int PEND_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteW,
    input  logic [ADDR_WIDTH-1:0] RdW,
    input  logic [DATA_WIDTH-1:0] ResultW,
    input  logic                  IssueD,
    input  logic [ADDR_WIDTH-1:0] RdD,
    input  logic [ADDR_WIDTH-1:0] Rs1D,
    input  logic [ADDR_WIDTH-1:0] Rs2D,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2,
    output logic                  Busy1,
    output logic                  Busy2,
    output logic                  PendOverflow
);

    localparam int NUM_REGS = 2**ADDR_WIDTH;
    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;
    localparam logic [PEND_WIDTH-1:0] PEND_ONE = PEND_WIDTH'(1);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [PEND_WIDTH-1:0] pend [NUM_REGS];
    logic                  ovf_set;
    logic                  wr_en;

    // Saturating counter update: issue counts up, retire counts down,
    // both together cancel out, and the ends of the range hold.
    function automatic logic [PEND_WIDTH-1:0] pend_next(
        input logic [PEND_WIDTH-1:0] cur,
        input logic                  inc,
        input logic                  dec
    );
        logic [PEND_WIDTH-1:0] nxt;
        nxt = cur;
        if (inc && !dec) begin
            if (cur != PEND_MAX) nxt = cur + PEND_ONE;
        end else if (dec && !inc) begin
            if (cur != '0) nxt = cur - PEND_ONE;
        end
        return nxt;
    endfunction

    // Writes to R0 are dropped so it stays zero.
    always_comb begin
        wr_en = RegWriteW && (RdW != '0);
    end

    // Register array: cleared by reset, written from the writeback stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[RdW] <= ResultW;
        end
    end

    // Pending counters; R0 is never tracked so it can never look busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) pend[i] <= '0;
        end else begin
            pend[0] <= '0;
            for (int i = 1; i < NUM_REGS; i++) begin
                pend[i] <= pend_next(pend[i],
                                     IssueD    && (RdD == ADDR_WIDTH'(i)),
                                     RegWriteW && (RdW == ADDR_WIDTH'(i)));
            end
        end
    end

    // An issue into a full counter is an error unless a retire to the
    // same register in this cycle makes room for it.
    always_comb begin
        ovf_set = IssueD && (RdD != '0) && (pend[RdD] == PEND_MAX)
                  && !(RegWriteW && (RdW == RdD));
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PendOverflow <= 1'b0;
        end else if (ovf_set) begin
            PendOverflow <= 1'b1;
        end
    end

    // Read port 1: zero for R0 or while in reset, bypass a same-cycle write.
    always_comb begin
        RD1 = '0;
        if (rst && (Rs1D != '0)) begin
            if (RegWriteW && (RdW == Rs1D)) RD1 = ResultW;
            else                            RD1 = regs[Rs1D];
        end
    end

    // Read port 2: same structure as port 1.
    always_comb begin
        RD2 = '0;
        if (rst && (Rs2D != '0)) begin
            if (RegWriteW && (RdW == Rs2D)) RD2 = ResultW;
            else                            RD2 = regs[Rs2D];
        end
    end

    // Busy flags: the last in-flight write retiring now is bypassed, so
    // it does not stall decode.
    always_comb begin
        Busy1 = (pend[Rs1D] != '0)
                && !(RegWriteW && (RdW == Rs1D) && (pend[Rs1D] == PEND_ONE));
        Busy2 = (pend[Rs2D] != '0)
                && !(RegWriteW && (RdW == Rs2D) && (pend[Rs2D] == PEND_ONE));
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed testbench for regfile_scoreboard: a table of single-cycle
// vectors followed by hand-written multi-cycle sequences for counter
// saturation, overflow and asynchronous reset.
`timescale 1ns/1ps

module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteW;
    logic [3:0]  RdW;
    logic [15:0] ResultW;
    logic        IssueD;
    logic [3:0]  RdD;
    logic [3:0]  Rs1D;
    logic [3:0]  Rs2D;
    logic [15:0] RD1;
    logic [15:0] RD2;
    logic        Busy1;
    logic        Busy2;
    logic        PendOverflow;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic        we;
        logic [3:0]  rdw;
        logic [15:0] res;
        logic        iss;
        logic [3:0]  rdd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [15:0] e_rd1;
        logic [15:0] e_rd2;
        logic        e_b1;
        logic        e_b2;
        logic        e_ovf;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    regfile_scoreboard #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(4),
        .PEND_WIDTH(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RegWriteW   (RegWriteW),
        .RdW         (RdW),
        .ResultW     (ResultW),
        .IssueD      (IssueD),
        .RdD         (RdD),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .RD1         (RD1),
        .RD2         (RD2),
        .Busy1       (Busy1),
        .Busy2       (Busy2),
        .PendOverflow(PendOverflow)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic we, input logic [3:0] rdw, input logic [15:0] res,
                         input logic iss, input logic [3:0] rdd,
                         input logic [3:0] rs1, input logic [3:0] rs2);
        RegWriteW = we;
        RdW       = rdw;
        ResultW   = res;
        IssueD    = iss;
        RdD       = rdd;
        Rs1D      = rs1;
        Rs2D      = rs2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] e1, input logic [15:0] e2,
                         input logic eb1, input logic eb2, input logic eovf);
        n_vec++;
        if (RD1 !== e1 || RD2 !== e2 || Busy1 !== eb1 || Busy2 !== eb2 || PendOverflow !== eovf) begin
            n_fail++;
            $display("FAIL %s: got RD1=%h RD2=%h B1=%b B2=%b OVF=%b, want RD1=%h RD2=%h B1=%b B2=%b OVF=%b",
                     name, RD1, RD2, Busy1, Busy2, PendOverflow, e1, e2, eb1, eb2, eovf);
        end
    endtask

    initial begin
        //            we rdw  res       iss rdd  rs1  rs2   rd1       rd2       b1 b2 ovf
        vecs[0]  = '{0, 4'd0, 16'h0000, 0, 4'd0, 4'd3, 4'd0, 16'h0000, 16'h0000, 0, 0, 0};
        vecs[1]  = '{1, 4'd5, 16'hBEEF, 0, 4'd0, 4'd5, 4'd0, 16'hBEEF, 16'h0000, 0, 0, 0};
        vecs[2]  = '{0, 4'd0, 16'h0000, 0, 4'd0, 4'd5, 4'd0, 16'hBEEF, 16'h0000, 0, 0, 0};
        vecs[3]  = '{1, 4'd0, 16'h1234, 0, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 0, 0, 0};
        vecs[4]  = '{0, 4'd0, 16'h0000, 0, 4'd0, 4'd0, 4'd5, 16'h0000, 16'hBEEF, 0, 0, 0};
        vecs[5]  = '{1, 4'd7, 16'h1111, 0, 4'd0, 4'd7, 4'd0, 16'h1111, 16'h0000, 0, 0, 0};
        vecs[6]  = '{1, 4'd7, 16'h2222, 0, 4'd0, 4'd5, 4'd7, 16'hBEEF, 16'h2222, 0, 0, 0};
        vecs[7]  = '{0, 4'd0, 16'h0000, 0, 4'd0, 4'd7, 4'd7, 16'h2222, 16'h2222, 0, 0, 0};
        vecs[8]  = '{0, 4'd0, 16'h0000, 1, 4'd4, 4'd4, 4'd0, 16'h0000, 16'h0000, 0, 0, 0};
        vecs[9]  = '{0, 4'd0, 16'h0000, 1, 4'd4, 4'd4, 4'd0, 16'h0000, 16'h0000, 1, 0, 0};
        vecs[10] = '{1, 4'd4, 16'hAAAA, 0, 4'd0, 4'd4, 4'd0, 16'hAAAA, 16'h0000, 1, 0, 0};
        vecs[11] = '{1, 4'd4, 16'hBBBB, 0, 4'd0, 4'd4, 4'd0, 16'hBBBB, 16'h0000, 0, 0, 0};
        vecs[12] = '{0, 4'd0, 16'h0000, 0, 4'd0, 4'd4, 4'd4, 16'hBBBB, 16'hBBBB, 0, 0, 0};
        vecs[13] = '{1, 4'd9, 16'h0909, 0, 4'd0, 4'd9, 4'd0, 16'h0909, 16'h0000, 0, 0, 0};
        vecs[14] = '{0, 4'd0, 16'h0000, 0, 4'd0, 4'd9, 4'd0, 16'h0909, 16'h0000, 0, 0, 0};
        vecs[15] = '{0, 4'd0, 16'h0000, 1, 4'd6, 4'd0, 4'd6, 16'h0000, 16'h0000, 0, 0, 0};
        vecs[16] = '{1, 4'd6, 16'h6666, 1, 4'd6, 4'd0, 4'd6, 16'h0000, 16'h6666, 0, 0, 0};
        vecs[17] = '{0, 4'd0, 16'h0000, 0, 4'd0, 4'd0, 4'd6, 16'h0000, 16'h6666, 0, 1, 0};
        vecs[18] = '{1, 4'd6, 16'h6060, 0, 4'd0, 4'd0, 4'd6, 16'h0000, 16'h6060, 0, 0, 0};
        vecs[19] = '{0, 4'd0, 16'h0000, 1, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 0, 0, 0};
        vecs[20] = '{0, 4'd0, 16'h0000, 0, 4'd0, 4'd0, 4'd6, 16'h0000, 16'h6060, 0, 0, 0};

        // Reset held with a live writeback to the read address: outputs stay 0.
        rst = 1'b0;
        drive(1, 4'd3, 16'hFFFF, 1, 4'd3, 4'd3, 4'd3);
        #12;
        check("reset_outputs", 16'h0000, 16'h0000, 0, 0, 0);
        drive(0, 4'd0, 16'h0000, 0, 4'd0, 4'd0, 4'd0);
        tick();
        rst = 1'b1;
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].we, vecs[i].rdw, vecs[i].res, vecs[i].iss,
                  vecs[i].rdd, vecs[i].rs1, vecs[i].rs2);
            #1;
            check($sformatf("vec%0d", i), vecs[i].e_rd1, vecs[i].e_rd2,
                  vecs[i].e_b1, vecs[i].e_b2, vecs[i].e_ovf);
            tick();
        end

        // Fill R2's counter to max without overflow.
        for (int k = 0; k < 3; k++) begin
            drive(0, 4'd0, 16'h0000, 1, 4'd2, 4'd2, 4'd0);
            tick();
        end
        drive(0, 4'd0, 16'h0000, 0, 4'd0, 4'd2, 4'd0);
        #1;
        check("pend_full_no_ovf", 16'h0000, 16'h0000, 1, 0, 0);

        // Issue and retire together at max: no overflow, count unchanged.
        drive(1, 4'd2, 16'h2222, 1, 4'd2, 4'd2, 4'd0);
        #1;
        check("incdec_at_max_comb", 16'h2222, 16'h0000, 1, 0, 0);
        tick();
        drive(0, 4'd0, 16'h0000, 0, 4'd0, 4'd2, 4'd0);
        #1;
        check("incdec_at_max_after", 16'h2222, 16'h0000, 1, 0, 0);

        // Fourth plain issue overflows.
        drive(0, 4'd0, 16'h0000, 1, 4'd2, 4'd2, 4'd0);
        tick();
        drive(0, 4'd0, 16'h0000, 0, 4'd0, 4'd2, 4'd0);
        #1;
        check("overflow_set", 16'h2222, 16'h0000, 1, 0, 1);

        // Counter saturated at 3: three retires are needed to clear Busy.
        drive(1, 4'd2, 16'h0001, 0, 4'd0, 4'd2, 4'd0);
        #1;
        check("sat_retire1", 16'h0001, 16'h0000, 1, 0, 1);
        tick();
        drive(1, 4'd2, 16'h0002, 0, 4'd0, 4'd2, 4'd0);
        #1;
        check("sat_retire2", 16'h0002, 16'h0000, 1, 0, 1);
        tick();
        drive(1, 4'd2, 16'h0003, 0, 4'd0, 4'd2, 4'd0);
        #1;
        check("sat_retire3", 16'h0003, 16'h0000, 0, 0, 1);
        tick();
        drive(0, 4'd0, 16'h0000, 0, 4'd0, 4'd2, 4'd0);
        #1;
        check("sat_drained_ovf_sticky", 16'h0003, 16'h0000, 0, 0, 1);

        // Mid-operation asynchronous reset.
        drive(0, 4'd0, 16'h0000, 1, 4'd8, 4'd0, 4'd0);
        tick();
        drive(1, 4'd5, 16'h5555, 0, 4'd0, 4'd5, 4'd8);
        #1;
        check("pre_reset", 16'h5555, 16'h0000, 0, 1, 1);
        rst = 1'b0;
        #1;
        check("async_reset_clears", 16'h0000, 16'h0000, 0, 0, 0);
        tick();
        rst = 1'b1;
        drive(1, 4'd8, 16'h8888, 0, 4'd0, 4'd5, 4'd8);
        #1;
        check("post_reset_retire", 16'h0000, 16'h8888, 0, 0, 0);
        tick();
        drive(0, 4'd0, 16'h0000, 0, 4'd0, 4'd8, 4'd5);
        #1;
        check("post_reset_readback", 16'h8888, 16'h0000, 0, 0, 0);

        // Counter for R8 sat at 0: one issue then one retire clears it.
        drive(0, 4'd0, 16'h0000, 1, 4'd8, 4'd8, 4'd0);
        tick();
        drive(0, 4'd0, 16'h0000, 0, 4'd0, 4'd8, 4'd0);
        #1;
        check("post_reset_issue", 16'h8888, 16'h0000, 1, 0, 0);
        drive(1, 4'd8, 16'h8008, 0, 4'd0, 4'd8, 4'd0);
        #1;
        check("post_reset_last_retire", 16'h8008, 16'h0000, 0, 0, 0);
        tick();
        drive(0, 4'd0, 16'h0000, 0, 4'd0, 4'd8, 4'd8);
        #1;
        check("post_reset_idle", 16'h8008, 16'h8008, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
